// File: rtl/ledger_arbiter.sv
// -----------------------------------------------------------------------------
// ledger_arbiter
//
// Two-terminal round-robin arbiter in front of a single 64-bit account ledger.
// A granted terminal's transaction (deposit or withdrawal) is captured, executed
// against the ledger, and answered with strobes. The grant is then held until
// the terminal releases its request.
//
// Transaction timeline (req sampled at edge N):
//   N   : IDLE      -> CAPTURA    gnt set, round-robin pointer updated
//   N+1 : CAPTURA   -> EJECUTA    tipo/monto of the granted terminal latched
//   N+2 : EJECUTA   -> RESPUESTA  ledger, balance_actualizado, num_trans updated
//   N+3 : RESPUESTA -> ESPERA     balance_stb (+ entregar/fondos) pulse registered
//   N+4+: ESPERA    -> IDLE       once the granted req bit is low, gnt cleared
//
// Ports
//   clk                   system clock, rising edge
//   reset                 synchronous, active-high reset
//   carga_stb             load balance_inicial into the ledger (IDLE only)
//   balance_inicial[63:0] initial account balance
//   req[1:0]              level request, bit i = terminal i
//   tipo_trans_0/1        0 = deposit, 1 = withdrawal
//   monto_0/1[31:0]       unsigned transaction amount
//   gnt[1:0]              one-hot grant, zero when nobody is served
//   balance_actualizado   ledger value after the last executed transaction
//   balance_stb           one-cycle pulse, balance_actualizado valid
//   entregar_dinero       one-cycle pulse on a successful withdrawal
//   fondos_insuficientes  one-cycle pulse on a rejected withdrawal
//   ocupado               high in every state except IDLE
//   num_trans[15:0]       count of committed (non-zero) transactions, wraps
// -----------------------------------------------------------------------------
module ledger_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        carga_stb,
  input  logic [63:0] balance_inicial,
  input  logic [1:0]  req,
  input  logic        tipo_trans_0,
  input  logic        tipo_trans_1,
  input  logic [31:0] monto_0,
  input  logic [31:0] monto_1,
  output logic [1:0]  gnt,
  output logic [63:0] balance_actualizado,
  output logic        balance_stb,
  output logic        entregar_dinero,
  output logic        fondos_insuficientes,
  output logic        ocupado,
  output logic [15:0] num_trans
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAPTURA   = 3'd1,
    EJECUTA   = 3'd2,
    RESPUESTA = 3'd3,
    ESPERA    = 3'd4
  } state_t;

  state_t state, state_next;

  // Ledger and captured transaction
  logic [63:0] ledger;
  logic        tipo_q;
  logic [31:0] monto_q;

  // Round-robin pointer: index of the terminal served last. Reset to 1 so
  // that terminal 0 wins the first tie.
  logic        last_idx;

  // Outcome of the executed transaction, replayed as strobes in RESPUESTA
  logic        pay_q;
  logic        reject_q;

  // Combinational helpers
  logic [1:0]  gnt_pick;
  logic        release_gnt;
  logic [64:0] dep_sum;
  logic        fits;
  logic        nonzero;
  logic [63:0] exec_ledger;
  logic        exec_pay;
  logic        exec_reject;
  logic        exec_commit;

  // ---------------------------------------------------------------------------
  // Round-robin pick. With a single request that terminal wins; on a tie the
  // terminal not served last wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gnt_pick = 2'b00;
    unique case (req)
      2'b01:   gnt_pick = 2'b01;
      2'b10:   gnt_pick = 2'b10;
      2'b11:   gnt_pick = last_idx ? 2'b01 : 2'b10;
      default: gnt_pick = 2'b00;
    endcase
  end

  // The granted terminal has let go of its request.
  assign release_gnt = ((req & gnt) == 2'b00);

  // ---------------------------------------------------------------------------
  // Execute: new ledger value and outcome for the captured transaction.
  // Deposits saturate at all-ones; withdrawals that exceed the balance leave
  // the ledger untouched. A zero amount is a no-op that commits nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    dep_sum     = {1'b0, ledger} + {33'b0, monto_q};
    fits        = ({32'b0, monto_q} <= ledger);
    nonzero     = (monto_q != 32'd0);
    exec_ledger = ledger;
    exec_pay    = 1'b0;
    exec_reject = 1'b0;
    exec_commit = 1'b0;
    if (!tipo_q) begin
      exec_ledger = dep_sum[64] ? {64{1'b1}} : dep_sum[63:0];
      exec_commit = nonzero;
    end else if (fits) begin
      exec_ledger = ledger - {32'b0, monto_q};
      exec_pay    = nonzero;
      exec_commit = nonzero;
    end else begin
      // monto > ledger implies monto != 0, so this is always a real rejection.
      exec_reject = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    ocupado    = (state != IDLE);
    unique case (state)
      IDLE: begin
        // A load takes priority and swallows any request in the same cycle.
        if (!carga_stb && (req != 2'b00)) state_next = CAPTURA;
      end
      CAPTURA:   state_next = EJECUTA;
      EJECUTA:   state_next = RESPUESTA;
      RESPUESTA: state_next = ESPERA;
      ESPERA: begin
        if (release_gnt) state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ledger               <= 64'd0;
      balance_actualizado  <= 64'd0;
      num_trans            <= 16'd0;
      gnt                  <= 2'b00;
      last_idx             <= 1'b1;
      tipo_q               <= 1'b0;
      monto_q              <= 32'd0;
      pay_q                <= 1'b0;
      reject_q             <= 1'b0;
      balance_stb          <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      balance_stb          <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;

      unique case (state)
        IDLE: begin
          if (carga_stb) begin
            ledger <= balance_inicial;
          end else if (req != 2'b00) begin
            gnt      <= gnt_pick;
            last_idx <= gnt_pick[1];
          end
        end

        CAPTURA: begin
          // From here on the terminal's inputs no longer matter.
          tipo_q  <= gnt[1] ? tipo_trans_1 : tipo_trans_0;
          monto_q <= gnt[1] ? monto_1      : monto_0;
        end

        EJECUTA: begin
          ledger              <= exec_ledger;
          balance_actualizado <= exec_ledger;
          pay_q               <= exec_pay;
          reject_q            <= exec_reject;
          if (exec_commit) num_trans <= num_trans + 16'd1;
        end

        RESPUESTA: begin
          balance_stb          <= 1'b1;
          entregar_dinero      <= pay_q;
          fondos_insuficientes <= reject_q;
        end

        ESPERA: begin
          if (release_gnt) gnt <= 2'b00;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: doc/ledger_arbiter.md
LEDGER_ARBITER -- requirements
Module: ledger_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 carga_stb  input  1  loads balance_inicial into the ledger register.
REQ-005 balance_inicial  input  64  initial account balance.
REQ-006 req  input  2  level request per terminal; bit i belongs to terminal i.
REQ-007 tipo_trans_0, tipo_trans_1  input  1 each  transaction type: 0 = deposit, 1 = withdrawal.
REQ-008 monto_0, monto_1  input  32 each  transaction amount, unsigned.
REQ-009 gnt  output  2  one-hot grant; all-zero when no terminal is served.
REQ-010 balance_actualizado  output  64  ledger value after the last transaction.
REQ-011 balance_stb  output  1  one-cycle pulse; balance_actualizado is valid in that cycle.
REQ-012 entregar_dinero  output  1  one-cycle pulse on a successful withdrawal.
REQ-013 fondos_insuficientes  output  1  one-cycle pulse on a rejected withdrawal.
REQ-014 ocupado  output  1  high in every state except IDLE.
REQ-015 num_trans  output  16  count of committed transactions.

Function
REQ-016 The FSM SHALL have the states IDLE, CAPTURA, EJECUTA, RESPUESTA and ESPERA.
REQ-017 IDLE, carga_stb=1: the ledger SHALL load balance_inicial at that edge, and req SHALL be ignored in that cycle.
REQ-018 carga_stb SHALL be ignored in every state other than IDLE.
REQ-019 IDLE, carga_stb=0 and req!=0: the arbiter SHALL grant one terminal, go to CAPTURA, and set gnt at that edge.
REQ-020 Arbitration SHALL be round-robin:
- only one req set: grant that terminal;
- both set: grant the terminal not served last;
- after reset, terminal 0 wins a tie.
REQ-021 CAPTURA SHALL latch the granted terminal's tipo_trans and monto and then go to EJECUTA.
- Input changes after this edge SHALL have no effect on the transaction.
REQ-022 EJECUTA SHALL compute the new ledger value and go to RESPUESTA.
REQ-023 Deposit: ledger = ledger + zero-extended monto, saturating at 64'hFFFF_FFFF_FFFF_FFFF.
REQ-024 Withdrawal with monto <= ledger: ledger = ledger - monto, and the transaction is a success.
REQ-025 Withdrawal with monto > ledger: the ledger SHALL stay unchanged, and the transaction is a rejection.
REQ-026 monto = 0, either type: the ledger SHALL stay unchanged, no entregar_dinero or fondos_insuficientes pulse, and num_trans unchanged.
REQ-027 RESPUESTA SHALL pulse balance_stb for exactly one cycle.
- entregar_dinero or fondos_insuficientes pulses in the same cycle, as applicable.
- The state SHALL then move to ESPERA.
REQ-028 Latency: req sampled at edge N SHALL give gnt high after N and balance_stb high in the cycle after edge N+3.
REQ-029 balance_actualizado SHALL be registered, updated only at the edge that enters RESPUESTA, and held until the next such edge.
- A carga_stb load SHALL NOT update it.
REQ-030 num_trans SHALL increment on every deposit with monto != 0 and every successful withdrawal with monto != 0.
- It SHALL wrap from 16'hFFFF to 0.
REQ-031 ESPERA SHALL hold gnt until the granted terminal's req bit is 0, then clear gnt and return to IDLE on the same edge.
REQ-032 A granted terminal that drops req during CAPTURA or EJECUTA SHALL still have its transaction completed.
- ESPERA then exits after one cycle.
REQ-033 gnt SHALL never have both bits set, and SHALL never change between grant and the return to IDLE.

Reset
REQ-034 On reset:
- state = IDLE;
- ledger and balance_actualizado = 0;
- gnt, balance_stb, entregar_dinero, fondos_insuficientes and ocupado = 0;
- num_trans = 0;
- round-robin pointer favours terminal 0.
REQ-035 A reset asserted in any state SHALL abort the transaction in progress.
- No strobe SHALL pulse afterwards, and the ledger SHALL hold 0.
REQ-036 The first rising edge with reset=0 SHALL already evaluate IDLE inputs.

Verification
REQ-037 Reset, carga 1000, req=01 deposit 100 -> gnt=01, balance_stb 3 edges later, balance_actualizado=1100, num_trans=1.
REQ-038 Then req=10 withdrawal 50 -> gnt=10, entregar_dinero pulse, balance_actualizado=1050, num_trans=2.
REQ-039 Then req=01 withdrawal 2000 -> fondos_insuficientes pulse, balance_actualizado=1050, num_trans=2.
REQ-040 After reset, req=11 held, deposits of 1 each, with each req dropped in ESPERA and re-raised:
- grants in order 01, 10, 01;
- no cycle with gnt=11.
REQ-041 carga 64'hFFFF_FFFF_FFFF_FF00, deposit 32'h200 -> balance_actualizado=64'hFFFF_FFFF_FFFF_FFFF.
REQ-042 Reset asserted in EJECUTA -> all outputs 0 the next cycle, and no balance_stb for the aborted transaction.
